// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan sequencer.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESENT,
    ST_WAIT_RELEASE
  } state_e;

  localparam logic [3:0] COL_INIT = 4'b1000;

  function automatic logic [1:0] onehot2idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1000: idx = 2'd3;
      4'b0100: idx = 2'd2;
      4'b0010: idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/keypad_stable_cnt.sv
// Saturating 8-bit stability counter; hit_o flags that this enabled cycle reaches target_i.
module keypad_stable_cnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] target_i,
  output logic       hit_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = en_i && (({1'b0, count_q} + 9'd1) >= {1'b0, target_i});

endmodule

// File: rtl/keypad_scan_sequencer.sv
// Column-strobe scanner with press/release debounce and a valid/ack key-code handshake.
module keypad_scan_sequencer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_HOLD       = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] r3_r0,
  output logic [3:0] c3_c0,
  output logic [3:0] code,
  output logic       valid,
  input  logic       ack,
  output logic       busy
);

  // The one-hot sample that enters DEBOUNCE already counts as the first stable cycle,
  // so the press target is one less than the release target.
  localparam logic [7:0] PRESS_TARGET   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] RELEASE_TARGET = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] HOLD_LAST      = 8'(SCAN_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] code_q, code_d;

  logic       cnt_en;
  logic       cnt_zap;
  logic       cnt_clr;
  logic       cnt_hit;
  logic [7:0] cnt_target;
  logic [3:0] col_next;

  assign col_next   = {col_q[0], col_q[3:1]};
  assign cnt_target = (state_q == ST_DEBOUNCE) ? PRESS_TARGET : RELEASE_TARGET;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    hold_d  = 8'd0;
    cand_d  = cand_q;
    code_d  = code_q;
    cnt_en  = 1'b0;
    cnt_zap = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (hold_q >= HOLD_LAST) begin
          if (is_onehot(r3_r0)) begin
            cand_d  = r3_r0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (r3_r0 == cand_q) begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            code_d  = {onehot2idx(cand_q), onehot2idx(col_q)};
            state_d = ST_PRESENT;
          end
        end else begin
          state_d = ST_SCAN;
          col_d   = col_next;
        end
      end
      ST_PRESENT: begin
        if (ack) begin
          state_d = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (r3_r0 == 4'b0000) begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            state_d = ST_SCAN;
            col_d   = col_next;
          end
        end else begin
          cnt_zap = 1'b1;
        end
      end
      default: begin
        state_d = ST_SCAN;
        col_d   = COL_INIT;
      end
    endcase
  end

  // Counter restarts on every state change, and on any bounce while waiting for release.
  assign cnt_clr = (state_d != state_q) || cnt_zap;

  // NOTE: reset is synchronous, so it lives inside the clocked block and beats every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SCAN;
      col_q   <= COL_INIT;
      hold_q  <= 8'd0;
      cand_q  <= 4'b0000;
      code_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      hold_q  <= hold_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
    end
  end

  keypad_stable_cnt u_stable_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .target_i (cnt_target),
    .hit_o    (cnt_hit)
  );

  assign c3_c0 = col_q;
  assign code  = code_q;
  assign valid = (state_q == ST_PRESENT);
  assign busy  = (state_q != ST_SCAN);

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// Directed bench for keypad_scan_sequencer with a keypad model and an expected-code queue.
module tb_keypad_scan_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] r3_r0;
  logic [3:0] c3_c0;
  logic [3:0] code;
  logic       valid;
  logic       ack;
  logic       busy;

  // Keypad model: a pressed key closes row key_row onto column key_col.
  logic       key_en;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] rows_const;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_col;
  int         n;

  always #5 clock = ~clock;

  always_comb begin
    r3_r0 = rows_const;
    if (key_en) begin
      r3_r0 = ((c3_c0 & key_col) != 4'b0000) ? key_row : 4'b0000;
    end
  end

  keypad_scan_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .SCAN_HOLD       (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .r3_r0 (r3_r0),
    .c3_c0 (c3_c0),
    .code  (code),
    .valid (valid),
    .ack   (ack),
    .busy  (busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rot(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction

  task automatic wait_valid(input string tag, input int max_cycles, output int cycles);
    cycles = 0;
    while (valid !== 1'b1 && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    check({tag, "_valid_seen"}, {7'd0, valid}, 8'd1);
  endtask

  task automatic pop_compare(input string tag);
    logic [3:0] e;
    check({tag, "_sb_nonempty"}, {7'd0, exp_q.size() > 0}, 8'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_code"}, {4'd0, code}, {4'd0, e});
    end
  endtask

  initial begin
    reset      = 1'b1;
    ack        = 1'b0;
    key_en     = 1'b0;
    key_row    = 4'b0000;
    key_col    = 4'b0000;
    rows_const = 4'b0000;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_col", {4'd0, c3_c0}, 8'h08);
    check("rst_code", {4'd0, code}, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);

    // Idle sweep: column rotates right every cycle, wrapping 0001 -> 1000
    exp_col = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      check("idle_col", {4'd0, c3_c0}, {4'd0, exp_col});
      check("idle_valid", {7'd0, valid}, 8'd0);
      tick();
      exp_col = rot(exp_col);
    end

    // Clean press at c=0010, r=0100 -> code 1001
    key_row = 4'b0100;
    key_col = 4'b0010;
    key_en  = 1'b1;
    tick();
    tick();
    check("press_col_before", {4'd0, c3_c0}, 8'h02);
    exp_q.push_back(4'b1001);
    tick();
    check("press_busy", {7'd0, busy}, 8'd1);
    check("press_col_frozen", {4'd0, c3_c0}, 8'h02);
    wait_valid("press", 20, n);
    check("press_latency", 8'(n), 8'd3);
    pop_compare("press");
    ack = 1'b1;
    tick();
    ack    = 1'b0;
    key_en = 1'b0;
    check("ack_valid_low", {7'd0, valid}, 8'd0);
    check("ack_busy", {7'd0, busy}, 8'd1);
    check("ack_code_kept", {4'd0, code}, 8'h09);
    tick();
    tick();
    tick();
    check("release_busy", {7'd0, busy}, 8'd1);
    check("release_col_frozen", {4'd0, c3_c0}, 8'h02);
    tick();
    check("release_col_next", {4'd0, c3_c0}, 8'h01);
    check("release_scan", {7'd0, busy}, 8'd0);
    tick();
    check("resume_wrap", {4'd0, c3_c0}, 8'h08);

    // Bounce at c=1000: two matching samples then release
    key_row = 4'b1000;
    key_col = 4'b1000;
    key_en  = 1'b1;
    tick();
    check("bounce_enter", {7'd0, busy}, 8'd1);
    tick();
    check("bounce_hold", {7'd0, busy}, 8'd1);
    key_en = 1'b0;
    tick();
    check("bounce_scan", {7'd0, busy}, 8'd0);
    check("bounce_col", {4'd0, c3_c0}, 8'h04);
    check("bounce_valid", {7'd0, valid}, 8'd0);

    // Multi-key on every column, with a stray ack: never leaves SCAN
    rows_const = 4'b1010;
    ack        = 1'b1;
    exp_col    = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      check("multi_col", {4'd0, c3_c0}, {4'd0, exp_col});
      check("multi_busy", {7'd0, busy}, 8'd0);
      check("multi_valid", {7'd0, valid}, 8'd0);
      tick();
      exp_col = rot(exp_col);
    end
    rows_const = 4'b0000;
    ack        = 1'b0;

    // Held key at c=0001, r=0001 with late ack
    key_row = 4'b0001;
    key_col = 4'b0001;
    key_en  = 1'b1;
    exp_q.push_back(4'b0000);
    wait_valid("held", 40, n);
    pop_compare("held");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_valid", {7'd0, valid}, 8'd1);
      check("held_code", {4'd0, code}, 8'h00);
      check("held_col", {4'd0, c3_c0}, 8'h01);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("held_ack_valid", {7'd0, valid}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("held_wait_busy", {7'd0, busy}, 8'd1);
      check("held_wait_col", {4'd0, c3_c0}, 8'h01);
    end

    // Release, press the same key again, then reset while valid
    key_en = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("held_release", {7'd0, busy}, 8'd0);
    check("held_release_col", {4'd0, c3_c0}, 8'h08);
    key_en = 1'b1;
    exp_q.push_back(4'b0000);
    wait_valid("re_press", 40, n);
    pop_compare("re_press");
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    key_en = 1'b0;
    check("midrst_valid", {7'd0, valid}, 8'd0);
    check("midrst_col", {4'd0, c3_c0}, 8'h08);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    check("midrst_code", {4'd0, code}, 8'h00);
    check("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
